rle_buf_scheduler: RTL and testbench



---
 rtl/rle_pkg.sv | 22 ++
 rtl/rle_ptr_ctrl.sv | 42 ++++
 rtl/rle_buf_scheduler.sv | 226 ++++++++++++++++++++++
 tb/tb_rle_buf_scheduler.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rle_pkg.sv
// Shared types and defaults for the RLE pair buffer scheduler.
package rle_pkg;

    localparam int unsigned DEPTH_AW   = 8;
    localparam int unsigned UART_DBITS = 8;

    typedef enum logic [1:0] {
        W_IDLE,
        W_CNT,
        W_SYM
    } wr_state_t;

    typedef enum logic [2:0] {
        R_IDLE,
        R_CHK,
        R_RD,
        R_CAP,
        R_SEND,
        R_WAIT
    } rd_state_t;

endpackage

// File: rtl/rle_ptr_ctrl.sv
// Write/read pointers of the pair buffer; derives occupancy, full and RAM addresses.
module rle_ptr_ctrl
    import rle_pkg::*;
#(
    parameter int unsigned AW = DEPTH_AW
)(
    input  logic          clk,
    input  logic          reset,
    input  logic          i_wr_inc,
    input  logic          i_rd_inc,
    output logic [AW:0]   o_occupancy,
    output logic          o_full,
    output logic [AW-1:0] o_waddr,
    output logic [AW-1:0] o_raddr
);

    // Full means no room for a complete (count, symbol) pair.
    localparam logic [AW:0] FULL_LIM = (AW+1)'((2**AW) - 2);

    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;

    // Pointer registers; one extra bit distinguishes full from empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (i_wr_inc) r_wptr <= r_wptr + 1'b1;
            if (i_rd_inc) r_rptr <= r_rptr + 1'b1;
        end
    end

    // Occupancy, full flag and wrapped addresses.
    always_comb begin
        o_occupancy = r_wptr - r_rptr;
        o_full      = (o_occupancy > FULL_LIM);
        o_waddr     = r_wptr[AW-1:0];
        o_raddr     = r_rptr[AW-1:0];
    end

endmodule

// File: rtl/rle_buf_scheduler.sv
// Arbitrates the single RAM port between the RLE encoder (writer, fixed priority)
// and the UART drain sequencer (reader).
module rle_buf_scheduler
    import rle_pkg::*;
#(
    parameter int unsigned AW         = DEPTH_AW,
    parameter int unsigned TX_TIMEOUT = 2000000,
    parameter int unsigned TO_BITS    = 21
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enc_valid,
    input  logic [UART_DBITS-1:0] enc_count,
    input  logic [UART_DBITS-1:0] enc_symbol,
    output logic                  enc_ready,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout_err,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [AW-1:0]         mem_addr,
    output logic [UART_DBITS-1:0] mem_wdata,
    input  logic [UART_DBITS-1:0] mem_rdata,
    output logic [UART_DBITS-1:0] tx_data,
    output logic                  tx_start,
    input  logic                  tx_done,
    output logic [AW:0]           occupancy
);

    // Wait counter value on the last permitted R_WAIT cycle.
    localparam logic [TO_BITS-1:0] TO_LIM = TO_BITS'(TX_TIMEOUT - 1);

    wr_state_t r_wstate, w_wstate_nxt;
    rd_state_t r_rstate, w_rstate_nxt;

    logic [UART_DBITS-1:0] r_cnt;
    logic [UART_DBITS-1:0] r_sym;
    logic [UART_DBITS-1:0] r_tx_data;
    logic [TO_BITS-1:0]    r_to_cnt;
    logic                  r_timeout_err;

    logic                  w_full;
    logic [AW-1:0]         w_waddr;
    logic [AW-1:0]         w_raddr;
    logic [AW:0]           w_occ;
    logic                  w_accept;
    logic                  w_wr_port;
    logic                  w_wr_inc;
    logic [UART_DBITS-1:0] w_wr_data;
    logic                  w_rd_port;
    logic                  w_rd_inc;
    logic                  w_cap;
    logic                  w_to_clr;
    logic                  w_err_clr;
    logic                  w_err_set;

    rle_ptr_ctrl #(
        .AW (AW)
    ) u_ptr (
        .clk         (clk),
        .reset       (reset),
        .i_wr_inc    (w_wr_inc),
        .i_rd_inc    (w_rd_inc),
        .o_occupancy (w_occ),
        .o_full      (w_full),
        .o_waddr     (w_waddr),
        .o_raddr     (w_raddr)
    );

    assign w_accept    = enc_valid && enc_ready;
    assign enc_ready   = !w_full && (r_wstate == W_IDLE);
    assign busy        = (r_rstate != R_IDLE);
    assign tx_data     = r_tx_data;
    assign timeout_err = r_timeout_err;
    assign occupancy   = w_occ;

    // Writer and reader state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wstate <= W_IDLE;
            r_rstate <= R_IDLE;
        end else begin
            r_wstate <= w_wstate_nxt;
            r_rstate <= w_rstate_nxt;
        end
    end

    // Writer: latch the pair on handshake, then spend one port cycle per byte.
    always_comb begin
        w_wstate_nxt = r_wstate;
        w_wr_port    = 1'b0;
        w_wr_inc     = 1'b0;
        w_wr_data    = '0;
        case (r_wstate)
            W_IDLE: begin
                if (w_accept) w_wstate_nxt = W_CNT;
            end
            W_CNT: begin
                w_wr_port    = 1'b1;
                w_wr_inc     = 1'b1;
                w_wr_data    = r_cnt;
                w_wstate_nxt = W_SYM;
            end
            W_SYM: begin
                w_wr_port    = 1'b1;
                w_wr_inc     = 1'b1;
                w_wr_data    = r_sym;
                w_wstate_nxt = W_IDLE;
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    // Pair holding registers loaded on the encoder handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_sym <= '0;
        end else if (w_accept) begin
            r_cnt <= enc_count;
            r_sym <= enc_symbol;
        end
    end

    // Reader: live empty check, read when the writer leaves the port free, send, await tx_done.
    always_comb begin
        w_rstate_nxt = r_rstate;
        w_rd_port    = 1'b0;
        w_rd_inc     = 1'b0;
        w_cap        = 1'b0;
        w_to_clr     = 1'b0;
        w_err_clr    = 1'b0;
        w_err_set    = 1'b0;
        tx_start     = 1'b0;
        done         = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                if (start) begin
                    w_err_clr    = 1'b1;
                    w_rstate_nxt = R_CHK;
                end
            end
            R_CHK: begin
                if (w_occ == '0) begin
                    done         = 1'b1;
                    w_rstate_nxt = R_IDLE;
                end else begin
                    w_rstate_nxt = R_RD;
                end
            end
            R_RD: begin
                if (!w_wr_port) begin
                    w_rd_port    = 1'b1;
                    w_rstate_nxt = R_CAP;
                end
            end
            R_CAP: begin
                w_cap        = 1'b1;
                w_rd_inc     = 1'b1;
                w_rstate_nxt = R_SEND;
            end
            R_SEND: begin
                tx_start     = 1'b1;
                w_to_clr     = 1'b1;
                w_rstate_nxt = R_WAIT;
            end
            R_WAIT: begin
                if (tx_done) begin
                    w_rstate_nxt = R_CHK;
                end else if (r_to_cnt == TO_LIM) begin
                    w_err_set    = 1'b1;
                    done         = 1'b1;
                    w_rstate_nxt = R_IDLE;
                end
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    // Single RAM port: the writer always wins; the reader only drives it when granted.
    always_comb begin
        mem_en    = w_wr_port || w_rd_port;
        mem_we    = w_wr_port;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_wr_port) begin
            mem_addr  = w_waddr;
            mem_wdata = w_wr_data;
        end else if (w_rd_port) begin
            mem_addr  = w_raddr;
        end
    end

    // Transmit byte register, loaded from the RAM one cycle after the read.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_data <= '0;
        end else if (w_cap) begin
            r_tx_data <= mem_rdata;
        end
    end

    // tx_done wait counter, restarted on every tx_start.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_to_cnt <= '0;
        end else if (w_to_clr) begin
            r_to_cnt <= '0;
        end else if (r_rstate == R_WAIT) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    // Sticky timeout flag, cleared when a new drain is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_timeout_err <= 1'b0;
        end else if (w_err_clr) begin
            r_timeout_err <= 1'b0;
        end else if (w_err_set) begin
            r_timeout_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rle_buf_scheduler.sv
// Bench for rle_buf_scheduler: small RAM and UART transmitter models plus a byte scoreboard.
module tb_rle_buf_scheduler;

    localparam int unsigned AW  = 3;
    localparam int unsigned TMO = 50;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enc_valid = 1'b0;
    logic [7:0]    enc_count = '0;
    logic [7:0]    enc_symbol = '0;
    logic          enc_ready;
    logic          start = 1'b0;
    logic          busy;
    logic          done;
    logic          timeout_err;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata = '0;
    logic [7:0]    tx_data;
    logic          tx_start;
    logic          tx_done = 1'b0;
    logic [AW:0]   occupancy;

    int unsigned vectors = 0;
    int unsigned errs = 0;
    int unsigned cyc = 0;

    logic [7:0]  exp_q[$];
    logic [7:0]  ram [0:(2**AW)-1];
    int unsigned nwrites = 0;
    logic [AW-1:0] last_waddr = '0;
    logic        wrap_seen = 1'b0;

    logic        mute = 1'b0;
    logic        tx_pend = 1'b0;
    int unsigned tx_wait = 0;
    logic [7:0]  tx_held = '0;
    logic        want_first = 1'b0;
    int unsigned first_ts_cyc = 0;
    int unsigned last_ts_cyc = 0;
    int unsigned done_cnt = 0;
    int unsigned done_cyc = 0;

    rle_buf_scheduler #(
        .AW         (AW),
        .TX_TIMEOUT (TMO),
        .TO_BITS    (21)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enc_valid   (enc_valid),
        .enc_count   (enc_count),
        .enc_symbol  (enc_symbol),
        .enc_ready   (enc_ready),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_done     (tx_done),
        .occupancy   (occupancy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous single-port RAM with one-cycle read latency.
    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            ram[mem_addr] <= mem_wdata;
            nwrites = nwrites + 1;
            if (mem_addr == '0 && last_waddr == '1) wrap_seen = 1'b1;
            last_waddr = mem_addr;
        end
        if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
    end

    // Transmitter model and scoreboard: check each sent byte, answer tx_done 20 cycles later.
    always @(negedge clk) begin
        tx_done = 1'b0;
        if (tx_pend) begin
            if (tx_wait == 0) begin
                tx_pend = 1'b0;
                if (!mute) begin
                    tx_done = 1'b1;
                    vectors++;
                    if (tx_data !== tx_held) begin
                        errs++;
                        $display("FAIL tx_hold: tx_data got %h want %h at tx_done", tx_data, tx_held);
                    end
                end
            end else begin
                tx_wait--;
            end
        end
        if (tx_start) begin
            vectors++;
            if (exp_q.size() == 0) begin
                errs++;
                $display("FAIL tx_byte: got %h with nothing expected", tx_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (tx_data !== e) begin
                    errs++;
                    $display("FAIL tx_byte: got %h want %h", tx_data, e);
                end
            end
            tx_held = tx_data;
            tx_pend = 1'b1;
            tx_wait = 19;
            last_ts_cyc = cyc;
            if (want_first) begin
                first_ts_cyc = cyc;
                want_first = 1'b0;
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic put_pair(input logic [7:0] c, input logic [7:0] s, input int unsigned budget);
        int unsigned n = 0;
        @(negedge clk);
        enc_valid = 1'b1;
        enc_count = c;
        enc_symbol = s;
        while (!enc_ready && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!enc_ready) begin
            vectors++;
            errs++;
            $display("FAIL put_pair: enc_ready got 0 want 1 after %0d cycles", n);
        end else begin
            exp_q.push_back(c);
            exp_q.push_back(s);
        end
        @(negedge clk);
        enc_valid = 1'b0;
    endtask

    task automatic pulse_start(output int unsigned t);
        @(negedge clk);
        start = 1'b1;
        t = cyc;
        want_first = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int unsigned base, input int unsigned budget);
        int unsigned n = 0;
        while (done_cnt == base && n < budget) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (done_cnt == base) begin
            errs++;
            $display("FAIL wait_done: done got 0 pulses want 1 within %0d cycles", budget);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({enc_ready, busy, done, timeout_err, mem_en, mem_we, tx_start} !== 7'b1000000) begin
            errs++;
            $display("FAIL reset_flags: got %b want 1000000",
                     {enc_ready, busy, done, timeout_err, mem_en, mem_we, tx_start});
        end
        vectors++;
        if ({mem_addr, mem_wdata, tx_data, occupancy} !== '0) begin
            errs++;
            $display("FAIL reset_buses: addr %h wdata %h tx_data %h occ %0d want all 0",
                     mem_addr, mem_wdata, tx_data, occupancy);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write;
        logic [7:0] want [4];
        want[0] = 8'd3; want[1] = 8'h41; want[2] = 8'd1; want[3] = 8'h42;
        put_pair(8'd3, 8'h41, 50);
        put_pair(8'd1, 8'h42, 50);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (ram[i] !== want[i]) begin
                errs++;
                $display("FAIL write_ram[%0d]: got %h want %h", i, ram[i], want[i]);
            end
        end
        vectors++;
        if (occupancy !== 4'd4 || busy !== 1'b0) begin
            errs++;
            $display("FAIL write_state: occupancy %0d busy %b want 4 0", occupancy, busy);
        end
    endtask

    task automatic test_drain;
        int unsigned t;
        int unsigned base;
        base = done_cnt;
        pulse_start(t);
        wait_done(base, 1000);
        repeat (10) @(negedge clk);
        vectors++;
        if (first_ts_cyc - t !== 4) begin
            errs++;
            $display("FAIL drain_latency: got %0d want 4 cycles", first_ts_cyc - t);
        end
        vectors++;
        if (done_cnt - base !== 1) begin
            errs++;
            $display("FAIL drain_done_count: got %0d want 1", done_cnt - base);
        end
        vectors++;
        if (occupancy !== '0 || exp_q.size() != 0 || busy !== 1'b0) begin
            errs++;
            $display("FAIL drain_end: occupancy %0d unsent %0d busy %b want 0 0 0",
                     occupancy, exp_q.size(), busy);
        end
    endtask

    task automatic test_full;
        int unsigned acc = 0;
        int unsigned base_w;
        int unsigned t;
        int unsigned base;
        base_w = nwrites;
        @(negedge clk);
        enc_valid = 1'b1;
        enc_count = 8'd10;
        enc_symbol = 8'h61;
        for (int i = 0; i < 40; i++) begin
            if (enc_ready) begin
                exp_q.push_back(enc_count);
                exp_q.push_back(enc_symbol);
                acc++;
            end
            @(negedge clk);
            enc_count = 8'(10 + acc);
            enc_symbol = 8'(8'h61 + acc);
        end
        vectors++;
        if (acc !== 4) begin
            errs++;
            $display("FAIL full_accepted: got %0d want 4 pairs", acc);
        end
        vectors++;
        if (nwrites - base_w !== 8) begin
            errs++;
            $display("FAIL full_writes: got %0d want 8", nwrites - base_w);
        end
        vectors++;
        if (occupancy !== 4'd8 || enc_ready !== 1'b0) begin
            errs++;
            $display("FAIL full_state: occupancy %0d enc_ready %b want 8 0", occupancy, enc_ready);
        end
        enc_valid = 1'b0;
        base = done_cnt;
        pulse_start(t);
        wait_done(base, 2000);
        vectors++;
        if (occupancy !== '0 || exp_q.size() != 0) begin
            errs++;
            $display("FAIL full_drain: occupancy %0d unsent %0d want 0 0", occupancy, exp_q.size());
        end
    endtask

    task automatic test_collision;
        int unsigned t;
        int unsigned base;
        put_pair(8'd5, 8'h44, 50);
        put_pair(8'd2, 8'h45, 50);
        repeat (2) @(negedge clk);
        base = done_cnt;
        pulse_start(t);
        // now in the reader's R_CHK cycle: present a pair so its writes land on R_RD
        vectors++;
        if (enc_ready !== 1'b1) begin
            errs++;
            $display("FAIL collide_ready: enc_ready got %b want 1", enc_ready);
        end
        enc_valid = 1'b1;
        enc_count = 8'd7;
        enc_symbol = 8'h43;
        exp_q.push_back(8'd7);
        exp_q.push_back(8'h43);
        @(negedge clk);
        enc_valid = 1'b0;
        vectors++;
        if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 3'd0) begin
            errs++;
            $display("FAIL collide_port: en %b we %b addr %0d want 1 1 0", mem_en, mem_we, mem_addr);
        end
        wait_done(base, 2000);
        vectors++;
        if (first_ts_cyc - t !== 6) begin
            errs++;
            $display("FAIL collide_latency: got %0d want 6 cycles", first_ts_cyc - t);
        end
        vectors++;
        if (occupancy !== '0 || exp_q.size() != 0) begin
            errs++;
            $display("FAIL collide_drain: occupancy %0d unsent %0d want 0 0", occupancy, exp_q.size());
        end
    endtask

    task automatic test_timeout;
        int unsigned t;
        int unsigned base;
        mute = 1'b1;
        put_pair(8'd9, 8'h54, 50);
        repeat (2) @(negedge clk);
        base = done_cnt;
        pulse_start(t);
        wait_done(base, 300);
        vectors++;
        if (done_cyc - last_ts_cyc !== TMO) begin
            errs++;
            $display("FAIL timeout_delay: got %0d want %0d cycles", done_cyc - last_ts_cyc, TMO);
        end
        vectors++;
        if (timeout_err !== 1'b1 || busy !== 1'b0 || occupancy !== 4'd1) begin
            errs++;
            $display("FAIL timeout_state: err %b busy %b occ %0d want 1 0 1",
                     timeout_err, busy, occupancy);
        end
        mute = 1'b0;
        base = done_cnt;
        pulse_start(t);
        vectors++;
        if (timeout_err !== 1'b0) begin
            errs++;
            $display("FAIL timeout_clear: err got %b want 0", timeout_err);
        end
        wait_done(base, 500);
        vectors++;
        if (occupancy !== '0 || exp_q.size() != 0 || timeout_err !== 1'b0) begin
            errs++;
            $display("FAIL timeout_resume: occ %0d unsent %0d err %b want 0 0 0",
                     occupancy, exp_q.size(), timeout_err);
        end
    endtask

    task automatic test_wrap;
        int unsigned t;
        int unsigned base;
        wrap_seen = 1'b0;
        put_pair(8'd20, 8'h70, 50);
        put_pair(8'd21, 8'h71, 50);
        repeat (2) @(negedge clk);
        base = done_cnt;
        pulse_start(t);
        for (int i = 0; i < 6; i++) put_pair(8'(22 + i), 8'(8'h72 + i), 1000);
        wait_done(base, 3000);
        vectors++;
        if (wrap_seen !== 1'b1) begin
            errs++;
            $display("FAIL wrap_addr: address 7->0 write seen %b want 1", wrap_seen);
        end
        vectors++;
        if (occupancy !== '0 || exp_q.size() != 0 || done_cnt - base !== 1) begin
            errs++;
            $display("FAIL wrap_drain: occ %0d unsent %0d dones %0d want 0 0 1",
                     occupancy, exp_q.size(), done_cnt - base);
        end
    endtask

    initial begin
        test_reset;
        test_write;
        test_drain;
        test_full;
        test_collision;
        test_timeout;
        test_wrap;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
